// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter: FSM states,
// owner codes and the data-streak counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_FETCH = 2'b01;
  localparam logic [1:0] OWN_DATA  = 2'b10;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the core's
// fetch port and data port, one transaction at a time, with registered mem_*.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    owner
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  logic                dm_wins;
  logic                grant_d;
  logic                grant_i;

  // Stalls are combinational so the core freezes in the request cycle; they
  // are gated by reset so every output reads 0 while reset is held.
  assign if_stall = reset & if_req & ~if_ready;
  assign dm_stall = reset & dm_req & ~dm_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    dm_wins = dm_req && ((streak_q < STREAK_MAX) || !if_req);
    case (state_q)
      IDLE: begin
        // The winner is decided on raw requests; a winner whose ready is
        // pulsing this cycle is the same request just served, so hold off.
        if (dm_wins) begin
          if (!dm_ready) begin
            state_d = GNT_D;
            grant_d = 1'b1;
          end
        end else if (if_req && !if_ready) begin
          state_d = GNT_I;
          grant_i = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= OWN_NONE;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      streak_q  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        owner     <= OWN_DATA;
        // Only grants taken while fetch is waiting count toward the streak.
        if (!if_req)                    streak_q <= '0;
        else if (streak_q < STREAK_MAX) streak_q <= streak_q + STREAK_ONE;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        owner     <= OWN_FETCH;
        streak_q  <= '0;
      end else if (state_q != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        owner   <= OWN_NONE;
        if (state_q == GNT_I) begin
          if_rdata <= mem_rdata;
          if_ready <= 1'b1;
        end else begin
          if (!mem_we) dm_rdata <= mem_rdata;
          dm_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both the core and the
// memory, driving and sampling on the falling clock edge.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          if_stall;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          dm_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    owner;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.DW(DW), .AW(AW), .MAX_DSTREAK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .dm_stall  (dm_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_mem_req();
    for (int i = 0; i < 6; i++) begin
      if (mem_req) break;
      tick();
    end
  endtask

  logic [1:0] exp_order [10];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with a pending fetch and mem_ack tied high
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0000;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = 32'h8C02_0004;
    mem_ack   = 1'b1;
    tick();
    tick();
    check("rst_mem_req",  mem_req,  0);
    check("rst_owner",    owner,    0);
    check("rst_if_stall", if_stall, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    reset = 1'b1;
    tick();
    check("f0_mem_req",  mem_req,  1);
    check("f0_owner",    owner,    2'b01);
    check("f0_mem_addr", mem_addr, 32'h0);
    check("f0_if_ready", if_ready, 0);
    check("f0_if_stall", if_stall, 1);
    tick();
    check("f0_if_ready_pulse", if_ready, 1);
    check("f0_if_rdata",       if_rdata, 32'h8C02_0004);
    check("f0_mem_req_drop",   mem_req,  0);
    check("f0_if_stall_low",   if_stall, 0);
    if_req  = 1'b0;
    mem_ack = 1'b0;
    tick();
    check("f0_if_ready_once", if_ready, 0);
    check("f0_idle_no_req",   mem_req,  0);

    // 2: load with memory latency 3; address change mid-grant is ignored
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h40;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ld_c1_mem_req", mem_req,  1);
    check("ld_c1_addr",    mem_addr, 32'h40);
    check("ld_c1_owner",   owner,    2'b10);
    check("ld_c1_we",      mem_we,   0);
    check("ld_c1_stall",   dm_stall, 1);
    dm_addr = 32'h44;
    tick();
    check("ld_c2_mem_req", mem_req,  1);
    check("ld_c2_addr",    mem_addr, 32'h40);
    check("ld_c2_ready",   dm_ready, 0);
    tick();
    check("ld_c3_mem_req", mem_req,  1);
    check("ld_c3_addr",    mem_addr, 32'h40);
    check("ld_c3_stall",   dm_stall, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ld_ready",    dm_ready, 1);
    check("ld_rdata",    dm_rdata, 32'hDEAD_BEEF);
    check("ld_mem_drop", mem_req,  0);
    check("ld_stall",    dm_stall, 0);
    dm_req = 1'b0;
    tick();
    check("ld_ready_once", dm_ready, 0);
    check("ld_idle_owner", owner,    0);

    // 3: simultaneous store and fetch; data first, fetch in the ready cycle
    if_req    = 1'b1;
    if_addr   = 32'h100;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h80;
    dm_wdata  = 32'h1234;
    mem_rdata = 32'h5555_AAAA;
    tick();
    check("st_owner",    owner,     2'b10);
    check("st_we",       mem_we,    1);
    check("st_wdata",    mem_wdata, 32'h1234);
    check("st_addr",     mem_addr,  32'h80);
    check("st_if_stall", if_stall,  1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_ready",       dm_ready, 1);
    check("st_rdata_keep",  dm_rdata, 32'hDEAD_BEEF);
    check("st_if_rdata",    if_rdata, 32'h8C02_0004);
    dm_req = 1'b0;
    tick();
    check("st_fetch_owner", owner,     2'b01);
    check("st_fetch_addr",  mem_addr,  32'h100);
    check("st_fetch_we",    mem_we,    0);
    check("st_fetch_wdata", mem_wdata, 0);
    mem_rdata = 32'h2442_0001;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("st_fetch_ready", if_ready, 1);
    check("st_fetch_rdata", if_rdata, 32'h2442_0001);
    if_req = 1'b0;
    tick();

    // 4: fairness with both requests held continuously
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    if_req  = 1'b1;
    if_addr = 32'h200;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      wait_mem_req();
      check($sformatf("fair_req_%0d", g), mem_req, 1);
      check($sformatf("fair_owner_%0d", g), owner, exp_order[g]);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    check("fair_end_owner", owner,   0);
    check("fair_end_req",   mem_req, 0);

    // 5: async reset in the middle of a data grant, then a late ack
    dm_req  = 1'b1;
    dm_addr = 32'h40;
    tick();
    check("ar_granted", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_mem_req_async", mem_req,  0);
    check("ar_owner_async",   owner,    0);
    check("ar_dm_stall",      dm_stall, 0);
    dm_req = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("ar_late_ack_ready", dm_ready, 0);
    check("ar_late_ack_req",   mem_req,  0);
    tick();
    check("ar_late_ack_ready2", dm_ready, 0);

    // 6: requester drops its request one cycle after the grant
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h44;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("dr_owner", owner, 2'b10);
    dm_req = 1'b0;
    tick();
    check("dr_req_held", mem_req,  1);
    check("dr_addr",     mem_addr, 32'h44);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("dr_ready", dm_ready, 1);
    check("dr_rdata", dm_rdata, 32'hCAFE_F00D);
    tick();
    check("dr_ready_once", dm_ready, 0);
    check("dr_no_regrant", mem_req,  0);
    tick();
    check("dr_idle_owner", owner,    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
